chaser_step_ctrl: RTL and testbench

Upstream control stage for the 7-segment fading chaser. Synchronises and debounces the raw speed switches and direction switch from the TinyTapeout pins, then generates the step tick and 3-bit chase position. The chaser consumes these to pick which segment to relight. Replaces the direct, unsynchronised pin sampling inside the chaser with clean, glitch-free control.

---
 rtl/chaser_step_ctrl_pkg.sv | 13 +
 rtl/chaser_step_ctrl_if.sv | 30 +++
 rtl/chaser_step_ctrl_sync_debounce.sv | 36 +++
 rtl/chaser_step_ctrl.sv | 76 +++++++
 tb/tb_chaser_step_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/chaser_step_ctrl_pkg.sv
// chaser_pkg: shared sizes, position type and step-period helper for the chaser control stage
// Ports: none (package)
package chaser_pkg;
    localparam int NUM_POSITIONS = 8;
    localparam int POS_WIDTH = $clog2(NUM_POSITIONS);
    localparam int SPEED_WIDTH = 3;
    typedef logic [POS_WIDTH-1:0] pos_t;
    // Period = speed level in the top bits, all-ones in the remaining low bits.
    function automatic logic [31:0] step_period(input logic [SPEED_WIDTH-1:0] level, input int counter_width);
        return ({29'd0, level} << (counter_width - SPEED_WIDTH))
             | ((32'd1 << (counter_width - SPEED_WIDTH)) - 32'd1);
    endfunction
endpackage

// File: rtl/chaser_step_ctrl_if.sv
// chaser_step_ctrl_if: raw switch inputs and step/position outputs of the chaser control stage
// Signals: speed_in[2:0] (raw, active-low), direction_in (raw, 1 = increment),
//          pause_in (raw, only with CHASER_PAUSE_EN), step_out, step_dir, position[2:0], speed_level[2:0]
// Modports: master drives the raw inputs, slave is the control stage.
interface chaser_step_ctrl_if;
    import chaser_pkg::*;
    logic [SPEED_WIDTH-1:0] speed_in;
    logic direction_in;
`ifdef CHASER_PAUSE_EN
    logic pause_in;
`endif
    logic step_out;
    logic step_dir;
    pos_t position;
    logic [SPEED_WIDTH-1:0] speed_level;
    modport master (
`ifdef CHASER_PAUSE_EN
        output pause_in,
`endif
        output speed_in, direction_in,
        input step_out, step_dir, position, speed_level
    );
    modport slave (
`ifdef CHASER_PAUSE_EN
        input pause_in,
`endif
        input speed_in, direction_in,
        output step_out, step_dir, position, speed_level
    );
endinterface

// File: rtl/chaser_step_ctrl_sync_debounce.sv
// sync_debounce: one-bit synchroniser followed by a stability debouncer
// Ports: clk, reset (sync, active-high), din (raw asynchronous input), stable (debounced value)
// A new value is accepted 2**DEBOUNCE_WIDTH cycles after the synchronised value first differs;
// any return to the stable value restarts the count.
module sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_WIDTH = 16,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable
);
    logic [SYNC_STAGES-1:0] sync;
    logic [DEBOUNCE_WIDTH-1:0] count;
    logic synced;
    assign synced = sync[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
            stable <= RESET_VAL;
            count <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (synced == stable) begin
                count <= '0;
            end else if (&count) begin
                stable <= synced;
                count <= '0;
            end else begin
                count <= count + DEBOUNCE_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/chaser_step_ctrl.sv
// chaser_step_ctrl: debounced speed/direction control producing the chase step tick and position
// Ports: clk, reset (sync, active-high), bus (chaser_step_ctrl_if.slave: raw switches in,
//        step_out/step_dir/position/speed_level out)
// Optional: define CHASER_PAUSE_EN to add a debounced pause_in that freezes counting.
module chaser_step_ctrl
    import chaser_pkg::*;
#(
    parameter int COUNTER_WIDTH = 24,
    parameter int DEBOUNCE_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic reset,
    chaser_step_ctrl_if.slave bus
);
    logic [SPEED_WIDTH-1:0] stable_speed;
    logic stable_dir;
    logic dir;
    logic paused;
    logic [COUNTER_WIDTH-1:0] count;
    logic [COUNTER_WIDTH-1:0] period;
    pos_t pos;
    logic step;

    // Speed switches are active-low, so they idle high out of reset.
    for (genvar i = 0; i < SPEED_WIDTH; i++) begin : g_speed
        sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH), .RESET_VAL(1'b1)) u_speed (
            .clk(clk), .reset(reset), .din(bus.speed_in[i]), .stable(stable_speed[i])
        );
    end

    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH), .RESET_VAL(1'b0)) u_dir (
        .clk(clk), .reset(reset), .din(bus.direction_in), .stable(stable_dir)
    );

`ifdef CHASER_PAUSE_EN
    logic dir_q;
    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH), .RESET_VAL(1'b0)) u_pause (
        .clk(clk), .reset(reset), .din(bus.pause_in), .stable(paused)
    );
    // Direction in effect is frozen while paused.
    always_ff @(posedge clk) begin
        if (reset) dir_q <= 1'b0;
        else if (!paused) dir_q <= stable_dir;
    end
    assign dir = dir_q;
`else
    assign paused = 1'b0;
    assign dir = stable_dir;
`endif

    assign period = COUNTER_WIDTH'(step_period(~stable_speed, COUNTER_WIDTH));

    // The >= compare lets a shorter period take effect on the next edge without overrunning.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            pos <= '0;
            step <= 1'b0;
        end else if (paused) begin
            step <= 1'b0;
        end else if (count >= period) begin
            count <= '0;
            step <= 1'b1;
            pos <= dir ? pos + POS_WIDTH'(1) : pos - POS_WIDTH'(1);
        end else begin
            count <= count + COUNTER_WIDTH'(1);
            step <= 1'b0;
        end
    end

    assign bus.step_out = step;
    assign bus.step_dir = dir;
    assign bus.position = pos;
    assign bus.speed_level = ~stable_speed;
endmodule

// File: tb/tb_chaser_step_ctrl.sv
// tb_chaser_step_ctrl: directed and randomized checks of chaser_step_ctrl against a behavioural model
module tb_chaser_step_ctrl;
`ifdef CHASER_PAUSE_EN
    localparam bit PAUSE = 1'b1;
`else
    localparam bit PAUSE = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    logic [2:0] spd_raw;
    logic dir_raw;
    logic pause_raw;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_step = 0;
    int last_gap = 0;

    logic [4:0] m_s1, m_s2, m_stab;
    int m_run[5];
    int m_cnt, m_pos;
    bit m_step, m_dirq;

    always #5 clk = ~clk;

    chaser_step_ctrl_if bus();
    assign bus.speed_in = spd_raw;
    assign bus.direction_in = dir_raw;
`ifdef CHASER_PAUSE_EN
    assign bus.pause_in = pause_raw;
`endif

    chaser_step_ctrl #(.COUNTER_WIDTH(8), .DEBOUNCE_WIDTH(3), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Behavioural model: inputs reach the debouncer two edges late, a value is accepted after
    // it has disagreed with the accepted one for 8 consecutive edges, and a step fires whenever
    // the cycles since the last step reach (level+1)*32-1.
    function automatic void model_step();
        int per;
        bit paused, dir;
        if (reset) begin
            m_s1 = 5'b00111;
            m_s2 = 5'b00111;
            m_stab = 5'b00111;
            foreach (m_run[b]) m_run[b] = 0;
            m_cnt = 0;
            m_pos = 0;
            m_step = 0;
            m_dirq = 0;
            return;
        end
        per = (8 - int'(m_stab[2:0])) * 32 - 1;
        paused = PAUSE && m_stab[4];
        dir = PAUSE ? m_dirq : m_stab[3];
        if (paused) m_step = 0;
        else if (m_cnt >= per) begin
            m_cnt = 0;
            m_step = 1;
            m_pos = (m_pos + (dir ? 1 : 7)) % 8;
        end else begin
            m_cnt++;
            m_step = 0;
        end
        if (!paused) m_dirq = m_stab[3];
        for (int b = 0; b < 5; b++) begin
            if (m_s2[b] != m_stab[b]) begin
                m_run[b]++;
                if (m_run[b] == 8) begin
                    m_stab[b] = m_s2[b];
                    m_run[b] = 0;
                end
            end else m_run[b] = 0;
        end
        m_s2 = m_s1;
        m_s1 = {pause_raw, dir_raw, spd_raw};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("step_out", bus.step_out, m_step);
        check("position", bus.position, m_pos);
        check("speed_level", bus.speed_level, 7 - m_stab[2:0]);
        check("step_dir", bus.step_dir, PAUSE ? m_dirq : m_stab[3]);
        if (bus.step_out) begin
            last_gap = cyc - last_step;
            last_step = cyc;
        end
    endtask

    task automatic wait_step(input string tag, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.step_out && n < budget);
        if (!bus.step_out) check({tag, "_timeout"}, bus.step_out, 1);
    endtask

    initial begin
        int n, prev;
        spd_raw = 3'b111;
        dir_raw = 1'b1;
        pause_raw = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_step", bus.step_out, 0);
        check("rst_pos", bus.position, 0);
        check("rst_speed", bus.speed_level, 0);
        check("rst_dir", bus.step_dir, 0);
        reset = 1'b0;

        wait_step("s1_first", 100, n);
        check("s1_first_gap", n, 32);
        for (int k = 0; k < 9; k++) begin
            prev = bus.position;
            wait_step("s1", 100, n);
            check("s1_gap", n, 32);
            check("s1_pos", bus.position, (prev + 1) % 8);
        end

        spd_raw = 3'b110;
        n = 0;
        do begin tick(); n++; end while (bus.speed_level != 3'd1 && n < 50);
        check("s2_accept", n, 10);
        wait_step("s2", 200, n);
        for (int k = 0; k < 2; k++) begin
            wait_step("s2", 200, n);
            check("s2_gap", n, 64);
        end

        for (int i = 0; i < 40; i++) begin
            spd_raw = ((i / 4) % 2) ? 3'b111 : 3'b110;
            tick();
            check("s3_level", bus.speed_level, 1);
        end
        spd_raw = 3'b110;
        wait_step("s3", 200, n);
        check("s3_gap", last_gap, 64);

        n = 0;
        while (m_cnt != 50 && n < 100) begin tick(); n++; end
        check("s4_reach50", m_cnt, 50);
        spd_raw = 3'b111;
        n = 0;
        do begin tick(); n++; end while (bus.speed_level != 3'd0 && n < 20);
        check("s4_accept", n, 10);
        check("s4_no_early", bus.step_out, 0);
        tick();
        check("s4_step", bus.step_out, 1);
        wait_step("s4", 100, n);
        check("s4_gap", n, 32);

        dir_raw = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.step_dir != 1'b0 && n < 20);
        check("s5_dir", bus.step_dir, 0);
        for (int k = 0; k < 10; k++) begin
            prev = bus.position;
            wait_step("s5", 100, n);
            check("s5_pos", bus.position, (prev + 7) % 8);
        end
        n = 0;
        while (m_cnt != 20 && n < 100) begin tick(); n++; end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s5_rst_step", bus.step_out, 0);
            check("s5_rst_pos", bus.position, 0);
        end
        reset = 1'b0;
        wait_step("s5_after_rst", 100, n);
        check("s5_rst_gap", n, 32);
        check("s5_rst_newpos", bus.position, 7);

`ifdef CHASER_PAUSE_EN
        pause_raw = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i >= 10) check("p_quiet", bus.step_out, 0);
        end
        pause_raw = 1'b0;
        wait_step("p_resume", 200, n);
`endif

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) spd_raw = 3'($urandom_range(4, 7));
            else if (r < 6) spd_raw[$urandom_range(0, 2)] ^= 1'b1;
            if ($urandom_range(0, 149) == 0) dir_raw = ~dir_raw;
            if (PAUSE && $urandom_range(0, 299) == 0) pause_raw = ~pause_raw;
            reset = ($urandom_range(0, 599) == 0);
            tick();
            if (reset) check("rnd_rst_step", bus.step_out, 0);
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
